// File: rtl/bldc_fault_pkg.sv
// Shared types and constants for the motor-drive fault recovery path.
// Default parameter values live here so the controller and its bench agree.
package bldc_fault_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_TRIP,
    ST_COOLDOWN,
    ST_LOCKOUT
  } fault_state_t;

  localparam int DEF_QUAL_CYCLES     = 2;
  localparam int DEF_COOLDOWN_CYCLES = 1000;
  localparam int DEF_MAX_RETRIES     = 3;
  localparam int DEF_STABLE_CYCLES   = 10000;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_bits(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_RETRY_W = $clog2(DEF_MAX_RETRIES + 1);

endpackage

// File: rtl/fault_timer.sv
// Reloadable down-counter: load wins over dec, and the count holds at zero.
module fault_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fault_recovery_controller.sv
// Qualifies the detector's fault flag, removes gate drive, cools down and retries,
// latching a lockout after MAX_RETRIES trips until the host clears it.
module fault_recovery_controller
  import bldc_fault_pkg::*;
#(
  parameter int QUAL_CYCLES     = DEF_QUAL_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int MAX_RETRIES     = DEF_MAX_RETRIES,
  parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               fault,
  input  logic                               enable_req,
  input  logic                               clear,
  output logic                               gate_enable,
  output logic                               fault_active,
  output logic                               lockout,
  output logic                               trip_pulse,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int QW = cnt_bits(QUAL_CYCLES - 1);
  localparam int SW = cnt_bits(STABLE_CYCLES);
  localparam int CW = cnt_bits(COOLDOWN_CYCLES - 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  fault_state_t  state_q, state_d;
  logic [QW-1:0] q_q, q_d;
  logic [SW-1:0] s_q, s_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          gate_enable_q, fault_active_q, lockout_q, trip_pulse_q;

  logic cd_load, cd_dec, cd_zero;

  // Loaded while in TRIP so the count is ready on the first COOLDOWN cycle.
  assign cd_load = (state_q == ST_TRIP) || ((state_q == ST_COOLDOWN) && fault);
  assign cd_dec  = (state_q == ST_COOLDOWN) && !fault;

  fault_timer #(.W(CW)) u_cooldown (
    .clk      (clk),
    .reset    (reset),
    .load     (cd_load),
    .load_val (CW'(COOLDOWN_CYCLES - 1)),
    .dec      (cd_dec),
    .zero     (cd_zero)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    s_d     = s_q;
    retry_d = retry_q;
    case (state_q)
      ST_IDLE: begin
        q_d = '0;
        s_d = '0;
        if (enable_req) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (fault) begin
          s_d = '0;
          if (q_q == QW'(QUAL_CYCLES - 1)) begin
            q_d     = '0;
            state_d = ST_TRIP;
            retry_d = (retry_q == RW'(MAX_RETRIES)) ? retry_q : retry_q + RW'(1);
          end else begin
            q_d = q_q + QW'(1);
          end
        end else begin
          q_d = '0;
          if (s_q >= SW'(STABLE_CYCLES - 1)) begin
            s_d     = SW'(STABLE_CYCLES);
            retry_d = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
        // A trip outranks the host dropping its run request.
        if (state_d != ST_TRIP && !enable_req) state_d = ST_IDLE;
      end
      ST_TRIP: begin
        state_d = (retry_q == RW'(MAX_RETRIES)) ? ST_LOCKOUT : ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cd_zero && !fault) begin
          state_d = enable_req ? ST_RUN : ST_IDLE;
          q_d     = '0;
          s_d     = '0;
        end
      end
      ST_LOCKOUT: begin
        if (clear && !fault) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      q_q            <= '0;
      s_q            <= '0;
      retry_q        <= '0;
      gate_enable_q  <= 1'b0;
      fault_active_q <= 1'b0;
      lockout_q      <= 1'b0;
      trip_pulse_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      q_q            <= q_d;
      s_q            <= s_d;
      retry_q        <= retry_d;
      gate_enable_q  <= (state_d == ST_RUN);
      fault_active_q <= (state_d == ST_TRIP) || (state_d == ST_COOLDOWN) ||
                        (state_d == ST_LOCKOUT);
      lockout_q      <= (state_d == ST_LOCKOUT);
      trip_pulse_q   <= (state_d == ST_TRIP);
    end
  end

  assign gate_enable  = gate_enable_q;
  assign fault_active = fault_active_q;
  assign lockout      = lockout_q;
  assign trip_pulse   = trip_pulse_q;
  assign retry_count  = retry_q;

endmodule

// File: tb/tb_fault_recovery_controller.sv
// Directed bench for fault_recovery_controller with short cooldown/stable windows.
module tb_fault_recovery_controller;
  import bldc_fault_pkg::*;

  localparam int QUAL = DEF_QUAL_CYCLES;
  localparam int COOL = 8;
  localparam int MAXR = DEF_MAX_RETRIES;
  localparam int STAB = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fault = 1'b0;
  logic enable_req = 1'b0;
  logic clear = 1'b0;
  logic gate_enable, fault_active, lockout, trip_pulse;
  logic [$clog2(MAXR+1)-1:0] retry_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       en;
    logic       f;
    logic       clr;
    logic       ge;
    logic       fa;
    logic       lo;
    logic       tp;
    logic [1:0] rc;
  } vec_t;

  vec_t tbl [16];

  fault_recovery_controller #(
    .QUAL_CYCLES     (QUAL),
    .COOLDOWN_CYCLES (COOL),
    .MAX_RETRIES     (MAXR),
    .STABLE_CYCLES   (STAB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fault        (fault),
    .enable_req   (enable_req),
    .clear        (clear),
    .gate_enable  (gate_enable),
    .fault_active (fault_active),
    .lockout      (lockout),
    .trip_pulse   (trip_pulse),
    .retry_count  (retry_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic ge, input logic fa, input logic lo,
                         input logic tp, input logic [1:0] rc);
    chk({name, ".gate_enable"},  {7'd0, gate_enable},  {7'd0, ge});
    chk({name, ".fault_active"}, {7'd0, fault_active}, {7'd0, fa});
    chk({name, ".lockout"},      {7'd0, lockout},      {7'd0, lo});
    chk({name, ".trip_pulse"},   {7'd0, trip_pulse},   {7'd0, tp});
    chk({name, ".retry_count"},  {6'd0, retry_count},  {6'd0, rc});
  endtask

  initial begin
    // Glitch rejection, first qualified trip and an uninterrupted cooldown.
    tbl[0] = '{en:1'b1, f:1'b0, clr:1'b0, ge:1'b1, fa:1'b0, lo:1'b0, tp:1'b0, rc:2'd0};
    tbl[1] = '{en:1'b1, f:1'b1, clr:1'b0, ge:1'b1, fa:1'b0, lo:1'b0, tp:1'b0, rc:2'd0};
    tbl[2] = '{en:1'b1, f:1'b0, clr:1'b0, ge:1'b1, fa:1'b0, lo:1'b0, tp:1'b0, rc:2'd0};
    tbl[3] = '{en:1'b1, f:1'b1, clr:1'b0, ge:1'b1, fa:1'b0, lo:1'b0, tp:1'b0, rc:2'd0};
    tbl[4] = '{en:1'b1, f:1'b0, clr:1'b0, ge:1'b1, fa:1'b0, lo:1'b0, tp:1'b0, rc:2'd0};
    tbl[5] = '{en:1'b1, f:1'b1, clr:1'b0, ge:1'b1, fa:1'b0, lo:1'b0, tp:1'b0, rc:2'd0};
    tbl[6] = '{en:1'b1, f:1'b1, clr:1'b0, ge:1'b0, fa:1'b1, lo:1'b0, tp:1'b1, rc:2'd1};
    for (int i = 7; i < 15; i++)
      tbl[i] = '{en:1'b1, f:1'b0, clr:1'b0, ge:1'b0, fa:1'b1, lo:1'b0, tp:1'b0, rc:2'd1};
    tbl[15] = '{en:1'b1, f:1'b0, clr:1'b0, ge:1'b1, fa:1'b0, lo:1'b0, tp:1'b0, rc:2'd1};

    step();
    step();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;

    // Normal start/stop: request during cycle 5, dropped during cycle 50.
    for (int c = 0; c < 60; c++) begin
      chk($sformatf("startstop.gate_enable c%0d", c), {7'd0, gate_enable},
          {7'd0, (c >= 6 && c <= 50)});
      chk($sformatf("startstop.trip_pulse c%0d", c), {7'd0, trip_pulse}, 8'd0);
      enable_req = (c >= 5 && c < 50);
      step();
    end

    for (int i = 0; i < 16; i++) begin
      enable_req = tbl[i].en;
      fault      = tbl[i].f;
      clear      = tbl[i].clr;
      step();
      chk_all($sformatf("table[%0d]", i), tbl[i].ge, tbl[i].fa, tbl[i].lo, tbl[i].tp, tbl[i].rc);
    end

    // Second trip, then a one-cycle fault on cooldown cycle 5 restarts the count.
    fault = 1'b1;
    step();
    step();
    chk_all("trip2", 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
    fault = 1'b0;
    for (int i = 0; i < 4; i++) step();
    fault = 1'b1;
    step();
    fault = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk_all($sformatf("reload g+%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    end
    step();
    chk_all("reload g+8", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);

    // Third trip locks out; run request and clear-under-fault are ignored.
    fault = 1'b1;
    step();
    chk_all("trip3 qual", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    step();
    chk_all("trip3", 1'b0, 1'b1, 1'b0, 1'b1, 2'd3);
    fault = 1'b0;
    step();
    chk_all("lockout entry", 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("lockout hold %0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
    end
    clear = 1'b1;
    fault = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("clear under fault %0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
    end
    fault = 1'b0;
    enable_req = 1'b0;
    step();
    chk_all("clear exit", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    clear = 1'b0;
    step();
    chk_all("idle after clear", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // One trip, recover, then STAB fault-free RUN cycles clear the retry count.
    enable_req = 1'b1;
    step();
    chk_all("stable run", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    fault = 1'b1;
    step();
    step();
    chk_all("stable trip", 1'b0, 1'b1, 1'b0, 1'b1, 2'd1);
    fault = 1'b0;
    for (int i = 0; i < COOL; i++) step();
    step();
    chk_all("stable rerun", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    for (int i = 0; i < STAB - 1; i++) step();
    chk_all("stable e+19", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    step();
    chk_all("stable e+20", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // Reset asserted between edges in the middle of a cooldown.
    fault = 1'b1;
    step();
    step();
    fault = 1'b0;
    step();
    step();
    chk_all("pre reset cooldown", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    #3;
    reset = 1'b1;
    #1;
    chk_all("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    enable_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk_all("post reset idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    enable_req = 1'b1;
    step();
    chk_all("post reset run", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fault_recovery_controller.md
# fault_recovery_controller

Consumer of the registered `fault` flag produced by the drive's fault detector. It qualifies the fault, removes gate drive from the inverter, then waits through a cooldown. It retries the motor a bounded number of times and latches a lockout that only an explicit clear can release. Its output `gate_enable` gates the PWM/commutation stage.

## Interface
Parameters:
- `QUAL_CYCLES`, default 2: consecutive cycles `fault` must be high in RUN to trip (≥1).
- `COOLDOWN_CYCLES`, default 1000: fault-free cycles required before a retry (≥1).
- `MAX_RETRIES`, default 3: trips allowed before lockout (≥1).
- `STABLE_CYCLES`, default 10000: fault-free RUN cycles after which the retry count clears (≥1).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `fault`, in, 1: fault flag from the detector, synchronous to `clk`.
- `enable_req`, in, 1: host request to run the motor (level).
- `clear`, in, 1: host lockout clear (level or pulse).
- `gate_enable`, out, 1: permits gate drive; high only in RUN.
- `fault_active`, out, 1: high in TRIP, COOLDOWN and LOCKOUT.
- `lockout`, out, 1: high in LOCKOUT.
- `trip_pulse`, out, 1: one-cycle strobe on entry to TRIP.
- `retry_count`, out, `$clog2(MAX_RETRIES+1)`: trips since the last clear or stable period.

## Operation
- States: IDLE, RUN, TRIP, COOLDOWN, LOCKOUT. Reset state is IDLE.
- All outputs are registered. Every output resets to 0, including `retry_count`.
- **IDLE:**
  - If `enable_req`=1, go to RUN.
  - `fault` is ignored.
- **RUN:**
  - Qualification counter `q` increments while `fault`=1 and clears to 0 when `fault`=0.
  - When `fault`=1 and `q`=QUAL_CYCLES-1, go to TRIP.
  - If `enable_req`=0 and no trip is occurring, go to IDLE and keep `retry_count`.
  - A trip has priority over `enable_req` dropping.
  - Stable counter `s` increments on each cycle with `fault`=0. When it reaches STABLE_CYCLES, `retry_count` clears to 0 and `s` saturates. `s` clears on entry to RUN and on any `fault`=1.
- **TRIP** (exactly 1 cycle):
  - `retry_count` increments, saturating at MAX_RETRIES.
  - If the incremented value equals MAX_RETRIES, go to LOCKOUT; otherwise go to COOLDOWN.
  - `trip_pulse` is high for the entry cycle only.
- **COOLDOWN:**
  - Timer loads COOLDOWN_CYCLES-1 on entry and decrements on each cycle with `fault`=0.
  - Any cycle with `fault`=1 reloads the timer to COOLDOWN_CYCLES-1.
  - When the timer is 0 and `fault`=0: go to RUN if `enable_req`=1, otherwise go to IDLE.
- **LOCKOUT:**
  - `gate_enable`=0 and `enable_req` is ignored.
  - `clear`=1 with `fault`=0 goes to IDLE and zeroes `retry_count`.
  - `clear`=1 with `fault`=1 is ignored; the condition is re-evaluated every cycle.
- `clear` has no effect in any state other than LOCKOUT.

## Timing
- Trip latency:
  - `fault` rises and is sampled at edge k.
  - TRIP is entered at edge k+QUAL_CYCLES-1.
  - `gate_enable` is low from that same edge, with no additional cycle.
- Cooldown of an uninterrupted fault-free period:
  - TRIP is at edge t and COOLDOWN is entered at t+1.
  - RUN is entered at t+1+COOLDOWN_CYCLES.
- Assertion of `reset` at any time immediately forces IDLE and sets all outputs to 0. Counters and the timer also clear.
- A single-cycle `fault` glitch with QUAL_CYCLES≥2 does not trip and clears `q`.

## Structure
- Shared package `bldc_fault_pkg` holds:
  - the state enum `fault_state_t`;
  - the width helper constants, including the `retry_count` width;
  - the default parameter constants, so that top level and testbench share them.
- One sub-module, `fault_timer`: a reloadable down-counter with ports `load`, `load_val`, `dec`, `zero`.
  - COOLDOWN uses one instance.
  - The stable counter may use a second instance, built as an up-count via a reload-from-max variant, or be written inline.
- The `q` counter is inline.

## Test plan
- **Normal start/stop:**
  - Stimulus: `enable_req`=1 at cycle 5, dropped at cycle 50.
  - Required response: `gate_enable` high from cycle 6 to 50 inclusive, then IDLE; no `trip_pulse`.
- **Glitch rejection (QUAL_CYCLES=2):**
  - Stimulus: 1-cycle `fault` pulses in RUN.
  - Required response: `gate_enable` stays 1.
  - Stimulus: a 2-cycle pulse.
  - Required response: `trip_pulse` on its second sample edge; `gate_enable` low that edge; `retry_count`=1.
- **Cooldown reload (COOLDOWN_CYCLES=8):**
  - Stimulus: `fault` re-asserted for 1 cycle at cooldown cycle 5.
  - Required response: RUN re-entered 8 fault-free cycles after the glitch, not before.
- **Lockout (MAX_RETRIES=3):**
  - Stimulus: three qualified trips.
  - Required response: `lockout`=1 after the third trip; `retry_count`=3; `enable_req` ignored.
  - Stimulus: `clear` with `fault`=1.
  - Required response: no exit.
  - Stimulus: `clear` with `fault`=0.
  - Required response: IDLE; `retry_count`=0.
- **Stable clear (STABLE_CYCLES=20):**
  - Stimulus: one trip, then recovery and 20 fault-free RUN cycles.
  - Required response: `retry_count` returns 0.
- **Reset mid-cooldown:**
  - Stimulus: `reset` pulsed during COOLDOWN.
  - Required response: all outputs 0 immediately; IDLE after release.
